// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit and the writeback extender.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

    // The reserved size 11 is reported through the same error path as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled little-endian load buffer to 32 bits.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (size)
            SIZE_BYTE: result = {{24{is_signed & raw[7]}}, raw[7:0]};
            SIZE_HALF: result = {{16{is_signed & raw[15]}}, raw[15:0]};
            default:   result = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: serialises byte/half/word loads and stores into
// one little-endian byte access per cycle against a byte-wide data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // upstream holds every req_* field stable until that edge.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [7:0]            mem_rdata,
    output logic [1:0]            dbg_state
);

    lsu_state_e            state;
    logic [1:0]            k;
    logic [MEM_ADDR_W-1:0] addr_lat;
    logic [1:0]            size_lat;
    logic                  write_lat;
    logic                  signed_lat;
    logic                  error_lat;
    logic [31:0]           wdata_lat;
    logic [31:0]           rbuf;
    logic [31:0]           ext_data;
    logic                  last_byte;
    logic                  in_access;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:MEM_ADDR_W];
    assign last_byte      = ({1'b0, k} == size_bytes(size_lat) - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= 2'd0;
            addr_lat   <= '0;
            size_lat   <= SIZE_BYTE;
            write_lat  <= 1'b0;
            signed_lat <= 1'b0;
            error_lat  <= 1'b0;
            wdata_lat  <= 32'd0;
            rbuf       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lat   <= req_addr[MEM_ADDR_W-1:0];
                        size_lat   <= req_size;
                        write_lat  <= req_write;
                        signed_lat <= req_signed;
                        wdata_lat  <= req_wdata;
                        rbuf       <= 32'd0;
                        k          <= 2'd0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            error_lat <= 1'b1;
                            state     <= DONE;
                        end else begin
                            error_lat <= 1'b0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_lat) begin
                        rbuf[{k, 3'b000} +: 8] <= mem_rdata;
                    end
                    k <= k + 2'd1;
                    if (last_byte) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    lsu_extend u_extend (
        .raw       (rbuf),
        .size      (size_lat),
        .is_signed (signed_lat),
        .result    (ext_data)
    );

    // Every output below is decoded from registered state only.
    assign in_access  = (state == ACCESS);
    assign req_ready  = (state == IDLE);
    assign mem_read   = in_access & ~write_lat;
    assign mem_write  = in_access & write_lat;
    assign mem_addr   = in_access ? addr_lat + MEM_ADDR_W'(k) : '0;
    assign mem_wdata  = mem_write ? wdata_lat[{k, 3'b000} +: 8] : 8'd0;
    assign resp_valid = (state == DONE);
    assign resp_error = resp_valid & error_lat;
    assign resp_rdata = (resp_valid & ~write_lat & ~error_lat) ? ext_data : 32'd0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_state;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_init;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int resp_cnt = 0;

    load_store_unit #(.MEM_ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Data memory environment: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 29 + 7);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!reset && resp_valid) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic sg);
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        n = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(addr + 32'(i))]) << (8 * i));
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        if (sg && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && (addr % 4) != 0);
    endfunction

    // Issues one request and checks every cycle up to and including the response.
    // With hold set, req_valid stays high carrying the nxt_* request after acceptance.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic hold,
                          input logic nxt_wr, input logic [1:0] nxt_sz, input logic nxt_sg,
                          input logic [31:0] nxt_addr, output logic [31:0] got);
        logic        mis;
        logic [31:0] exp_rdata;
        int          n;
        mis       = ref_misaligned(sz, addr);
        exp_rdata = (wr || mis) ? 32'd0 : ref_load(addr, sz, sg);
        n         = mis ? 0 : (1 << sz);
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_write  = nxt_wr;
            req_size   = nxt_sz;
            req_signed = nxt_sg;
            req_addr   = nxt_addr;
            req_wdata  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            check("acc_write", 32'(mem_write), 32'(wr));
            check("acc_read", 32'(mem_read), 32'(!wr));
            check("acc_addr", 32'(mem_addr), 32'(8'(addr + 32'(i))));
            check("acc_wdata", 32'(mem_wdata), wr ? 32'((wd >> (8 * i)) & 32'hFF) : 32'd0);
            check("acc_busy", 32'({resp_valid, req_ready}), 32'd0);
            if (wr) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
            @(posedge clk);
            @(negedge clk);
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_error", 32'(resp_error), 32'(mis));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_quiet", {mem_addr, mem_wdata, 14'd0, mem_read, mem_write}, 32'd0);
        check("resp_busy", 32'(req_ready), 32'd0);
        got = resp_rdata;
        n_done++;
        @(posedge clk);
    endtask

    task automatic req(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
        do_req(wr, sz, sg, addr, wd, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, got);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 29 + 7);
        reset = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_init = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp", {resp_valid, resp_error, 30'd0}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem", {mem_addr, mem_wdata, 14'd0, mem_read, mem_write}, 32'd0);

        // Word store aborted by reset once bytes 0 and 1 are written.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_k0", {mem_write, mem_addr}, {1'b1, 8'h40});
        @(posedge clk);
        @(negedge clk);
        check("abort_k1", {mem_write, mem_addr}, {1'b1, 8'h41});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_stop", {mem_write, mem_read, resp_valid}, 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("abort_noresp", {mem_write, resp_valid}, 32'd0);
        check("abort_b0", 32'(mem[8'h40]), 32'h44);
        check("abort_b1", 32'(mem[8'h41]), 32'h33);
        check("abort_b2", 32'(mem[8'h42]), 32'(ref_mem[8'h42]));
        check("abort_b3", 32'(mem[8'h43]), 32'(ref_mem[8'h43]));
        ref_mem[8'h40] = 8'h44;
        ref_mem[8'h41] = 8'h33;

        req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        check("word_load", got, 32'hDEAD_BEEF);
        req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_FF80, got);
        req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0, got);
        check("half_signed", got, 32'hFFFF_FF80);
        req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, got);
        check("byte_unsigned", got, 32'h0000_0080);
        req(1'b0, 2'd0, 1'b1, 32'h21, 32'd0, got);
        check("byte_signed", got, 32'hFFFF_FFFF);

        req(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, got);
        req(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234_5678, got);
        req(1'b0, 2'd3, 1'b0, 32'h30, 32'd0, got);

        // Held request during a wrapped-address half load.
        do_req(1'b0, 2'd1, 1'b0, 32'h1FE, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h05, got);
        req(1'b0, 2'd0, 1'b0, 32'h05, 32'd0, got);

        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i += 37) check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
        check("resp_count", resp_cnt, n_done);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
